// File: rtl/rv_fetch.sv
// Instruction fetch stage: one instruction per cycle from a synchronous-read memory.
// Stall holds the presented instruction in a skid register; a redirect causes one bubble.
module rv_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr_o,
  input  logic [31:0] instr_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, FLUSH} state_e;

  // Word-address mask; IMEM_SIZE is expected to be a power of two in K-words.
  localparam logic [15:0] ADDR_MASK = 16'(IMEM_SIZE * 1024 - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        misalign_q, misalign_d;
  logic        advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_out_q   <= 32'h0;
      valid_q    <= 1'b0;
      hold_q     <= 32'h0;
      hold_vld_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    misalign_d = 1'b0;

    // A bubble can never be stalled, so an empty output always refills.
    advance = !redirect_i && (!valid_q || !stall_i);

    if (redirect_i) begin
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      valid_d    = 1'b0;
      hold_vld_d = 1'b0;
      misalign_d = |redirect_pc_i[1:0];
      state_d    = FLUSH;
    end else if (advance) begin
      pc_out_d   = pc_q;
      valid_d    = 1'b1;
      pc_d       = pc_q + 32'd4;
      hold_vld_d = 1'b0;
      state_d    = RUN;
    end else if (state_q != HOLD) begin
      // Memory data for pc_out is only on instr_i in the first stalled cycle.
      hold_d     = instr_i;
      hold_vld_d = 1'b1;
      state_d    = HOLD;
    end
  end

  assign imem_addr_o = pc_q[17:2] & ADDR_MASK;
  assign instr_o     = hold_vld_q ? hold_q : instr_i;
  assign pc_o        = pc_out_q;
  assign valid_o     = valid_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_rv_fetch.sv
// Bench for rv_fetch: directed vector table, random stall/redirect against a PC-stream model,
// plus address wrap and asynchronous reset during a stall.
module tb_rv_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr_o;
  logic [31:0] instr_i = 32'h0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  // Behavioural view: next address to fetch, and the instruction presented to decode.
  logic [31:0] m_next;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_mis;

  rv_fetch #(.RESET_PC(32'h0), .IMEM_SIZE(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr_o  (imem_addr_o),
    .instr_i      (instr_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .valid_o      (valid_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  // Registered-read memory whose word i holds 0x1000_0000 + i.
  always @(posedge clk) instr_i <= 32'h1000_0000 + {16'h0, imem_addr_o};

  function automatic logic [31:0] mem_word(input logic [31:0] byte_pc);
    return 32'h1000_0000 + {16'h0, byte_pc[17:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_next  = 32'h0;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
  endtask

  // Drive inputs at a falling edge, advance one rising edge, return at the next falling edge.
  task automatic cyc(input logic s, input logic r, input logic [31:0] t);
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = t;
    @(posedge clk);
    m_mis = r && (t[1:0] != 2'b00);
    if (r) begin
      m_next  = {t[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (!(m_valid && s)) begin
      m_pc    = m_next;
      m_valid = 1'b1;
      m_next  = m_next + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic check_model();
    chk("valid", {31'h0, valid_o}, {31'h0, m_valid});
    chk("misalign", {31'h0, misalign_o}, {31'h0, m_mis});
    chk("imem_addr", {16'h0, imem_addr_o}, {16'h0, m_next[17:2]});
    if (m_valid) begin
      chk("pc", pc_o, m_pc);
      chk("instr", instr_o, mem_word(m_pc));
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        exp_vld;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [15:0] exp_addr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t, input logic v,
                              input logic [31:0] p, input logic [31:0] i, input logic [15:0] a,
                              input logic m);
    vec_t x;
    x.stall = s; x.redir = r; x.tgt = t; x.exp_vld = v;
    x.exp_pc = p; x.exp_instr = i; x.exp_addr = a; x.exp_mis = m;
    return x;
  endfunction

  initial begin
    vecs[0]  = mk(0, 0, 32'h0,     1, 32'h0,     32'h1000_0000, 16'h0001, 0);
    vecs[1]  = mk(0, 0, 32'h0,     1, 32'h4,     32'h1000_0001, 16'h0002, 0);
    vecs[2]  = mk(0, 0, 32'h0,     1, 32'h8,     32'h1000_0002, 16'h0003, 0);
    vecs[3]  = mk(1, 0, 32'h0,     1, 32'h8,     32'h1000_0002, 16'h0003, 0);
    vecs[4]  = mk(1, 0, 32'h0,     1, 32'h8,     32'h1000_0002, 16'h0003, 0);
    vecs[5]  = mk(1, 0, 32'h0,     1, 32'h8,     32'h1000_0002, 16'h0003, 0);
    vecs[6]  = mk(0, 0, 32'h0,     1, 32'hC,     32'h1000_0003, 16'h0004, 0);
    vecs[7]  = mk(0, 0, 32'h0,     1, 32'h10,    32'h1000_0004, 16'h0005, 0);
    vecs[8]  = mk(0, 1, 32'h100,   0, 32'h0,     32'h0,         16'h0040, 0);
    vecs[9]  = mk(0, 0, 32'h0,     1, 32'h100,   32'h1000_0040, 16'h0041, 0);
    vecs[10] = mk(0, 0, 32'h0,     1, 32'h104,   32'h1000_0041, 16'h0042, 0);
    vecs[11] = mk(1, 1, 32'h41,    0, 32'h0,     32'h0,         16'h0010, 1);
    vecs[12] = mk(1, 0, 32'h0,     1, 32'h40,    32'h1000_0010, 16'h0011, 0);
    vecs[13] = mk(0, 0, 32'h0,     1, 32'h44,    32'h1000_0011, 16'h0012, 0);
    vecs[14] = mk(0, 1, 32'h200,   0, 32'h0,     32'h0,         16'h0080, 0);
    vecs[15] = mk(0, 1, 32'h300,   0, 32'h0,     32'h0,         16'h00C0, 0);
    vecs[16] = mk(0, 0, 32'h0,     1, 32'h300,   32'h1000_00C0, 16'h00C1, 0);
    vecs[17] = mk(0, 0, 32'h0,     1, 32'h304,   32'h1000_00C1, 16'h00C2, 0);
    vecs[18] = mk(0, 1, 32'h3FFF8, 0, 32'h0,     32'h0,         16'hFFFE, 0);
    vecs[19] = mk(0, 0, 32'h0,     1, 32'h3FFF8, 32'h1000_FFFE, 16'hFFFF, 0);
    vecs[20] = mk(0, 0, 32'h0,     1, 32'h3FFFC, 32'h1000_FFFF, 16'h0000, 0);
    vecs[21] = mk(0, 0, 32'h0,     1, 32'h40000, 32'h1000_0000, 16'h0001, 0);

    model_reset();

    // Reset state.
    #2;
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_mis", {31'h0, misalign_o}, 32'h0);
    chk("rst_addr", {16'h0, imem_addr_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      cyc(vecs[i].stall, vecs[i].redir, vecs[i].tgt);
      chk($sformatf("v%0d_valid", i), {31'h0, valid_o}, {31'h0, vecs[i].exp_vld});
      chk($sformatf("v%0d_mis", i), {31'h0, misalign_o}, {31'h0, vecs[i].exp_mis});
      chk($sformatf("v%0d_addr", i), {16'h0, imem_addr_o}, {16'h0, vecs[i].exp_addr});
      if (vecs[i].exp_vld) begin
        chk($sformatf("v%0d_pc", i), pc_o, vecs[i].exp_pc);
        chk($sformatf("v%0d_instr", i), instr_o, vecs[i].exp_instr);
      end
    end

    // Random stall/redirect traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        s, r;
      logic [31:0] t;
      s = ($urandom_range(0, 99) < 35);
      r = ($urandom_range(0, 99) < 12);
      t = $urandom_range(0, 32'h3FFFF);
      if ($urandom_range(0, 7) == 0) t = t | ($urandom() & 32'hFFFC_0000);
      cyc(s, r, t);
      check_model();
    end

    // Asynchronous reset in the middle of a stall.
    cyc(0, 1, 32'h80);
    check_model();
    cyc(0, 0, 32'h0);
    check_model();
    cyc(1, 0, 32'h0);
    check_model();
    cyc(1, 0, 32'h0);
    check_model();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, valid_o}, 32'h0);
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_addr", {16'h0, imem_addr_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(1, 0, 32'h0);
    chk("restart_valid", {31'h0, valid_o}, 32'h1);
    chk("restart_pc", pc_o, 32'h0);
    chk("restart_instr", instr_o, 32'h1000_0000);
    cyc(0, 0, 32'h0);
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_fetch.md
RV_FETCH -- requirements
Module: rv_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the byte PC fetched first after reset.
REQ-002 SHALL have parameter IMEM_SIZE, default 64, giving the instruction memory depth in K-words; it sizes the address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr_o, output, 16 bits: word address to the instruction memory, equal to pc_q[17:2].
REQ-006 SHALL have port instr_i, input, 32 bits: registered memory read data, valid one cycle after the address.
REQ-007 SHALL have port stall_i, input, 1 bit: the consumer cannot accept the current instruction.
REQ-008 SHALL have port redirect_i, input, 1 bit: branch/jump taken; restart fetch at redirect_pc_i.
REQ-009 SHALL have port redirect_pc_i, input, 32 bits: redirect target byte address.
REQ-010 SHALL have port instr_o, output, 32 bits: instruction presented to decode.
REQ-011 SHALL have port pc_o, output, 32 bits: byte PC of instr_o.
REQ-012 SHALL have port valid_o, output, 1 bit: instr_o/pc_o hold a correct-path instruction.
REQ-013 SHALL have port misalign_o, output, 1 bit: one-cycle pulse flagging a redirect target with bits [1:0] != 0.

Function
REQ-014 SHALL keep pc_q (address being requested), pc_o, valid_o, hold_q (32b skid register), hold_vld and a 2-bit FSM {BOOT, RUN, HOLD, FLUSH}.
REQ-015 SHALL define advance = redirect_i==0 AND (valid_o==0 OR stall_i==0).
REQ-016 On advance: pc_o<=pc_q; valid_o<=1; pc_q<=pc_q+4 (32-bit modulo); hold_vld<=0; state<=RUN.
REQ-017 SHALL hold pc_q, pc_o and valid_o while valid_o==1 and stall_i==1; on the first such cycle hold_q<=instr_i, hold_vld<=1, state<=HOLD; later stall cycles leave hold_q unchanged.
REQ-018 SHALL drive instr_o = hold_vld ? hold_q : instr_i.
REQ-019 On redirect_i==1 (priority over stall_i): pc_q<={redirect_pc_i[31:2],2'b00}; valid_o<=0; hold_vld<=0; state<=FLUSH.
REQ-020 SHALL give a redirect asserted in cycle R this timing: R+1 valid_o=0 (instr_i is wrong-path); R+2 valid_o=1, pc_o=target, instr_o=mem[target] if no stall/redirect intervenes.
REQ-021 SHALL assert misalign_o in the cycle after a redirect whose target has [1:0]!=0, for exactly one cycle; fetch continues at the aligned address.
REQ-022 SHALL ignore stall_i while valid_o==0; the bubble never freezes fetch.
REQ-023 Address wrap: imem_addr_o takes pc_q[17:2], wrapping 0xFFFF->0x0000 at byte PC 0x3FFFC->0x40000; pc_o keeps the full 32-bit PC.
REQ-024 Back-to-back redirects in R and R+1: the second target wins; valid_o stays 0 through R+2.
REQ-025 Fetch throughput SHALL be one instruction per cycle with stall_i low and no redirect.

Reset
REQ-026 While rst_n==0: pc_q=RESET_PC, pc_o=0, valid_o=0, hold_q=0, hold_vld=0, misalign_o=0, state=BOOT, independent of clk.
REQ-027 First edge after rst_n rises: BOOT->RUN per REQ-016; pc_o=RESET_PC and valid_o=1 with instr_i=mem[RESET_PC/4].
REQ-028 Reset asserted mid-stall or mid-flush SHALL discard hold and redirect state immediately.

Verification (bench memory word i = 0x1000_0000+i)
REQ-029 Reset release, no stall -> pc_o 0,4,8,... on consecutive cycles; instr_o 0x10000000, 0x10000001, ...; valid_o high from cycle 1.
REQ-030 stall_i high 3 cycles while pc_o=0x8 -> pc_o=0x8 and instr_o=0x10000002 held; imem_addr_o=3 held; then pc_o=0xC, instr_o=0x10000003.
REQ-031 Redirect to 0x100 at pc_o=0x10 -> one valid_o=0 cycle, then pc_o=0x100, instr_o=0x10000040, then 0x104.
REQ-032 redirect_i and stall_i both high, target 0x41 -> misalign_o pulses once; fetch resumes at 0x40, instr_o=0x10000010.
REQ-033 Sequential fetch across byte PC 0x3FFFC -> imem_addr_o 0xFFFF then 0x0000; pc_o=0x40000.
REQ-034 rst_n low during HOLD -> valid_o=0 asynchronously; restart at RESET_PC.
